// File: rtl/alu_issue.sv
// Single-issue front end for an external two-stage ALU: decodes 16-bit instructions,
// reads an 8x16 register file, tracks two in-flight writebacks and stalls on register hazards.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  input  logic        alu_carry,
  input  logic        alu_sign,
  input  logic        alu_overflow,
  output logic        flag_carry,
  output logic        flag_sign,
  output logic        flag_overflow,
  output logic        illegal,
  output logic        busy,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {
    CLS_NOP,
    CLS_LI,
    CLS_ALU,
    CLS_ILL
  } op_class_e;

  typedef struct packed {
    logic       vld;
    logic [2:0] rd;
  } slot_t;

  logic [3:0]  op;
  logic [2:0]  rd;
  logic [2:0]  rs1;
  logic [2:0]  rs2;
  logic [7:0]  imm8;
  op_class_e   cls;

  logic [15:0] rf_q [8];
  slot_t       s1_q, s1_d;
  slot_t       s2_q, s2_d;
  logic [3:0]  opc_q, opc_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        ill_q, ill_d;
  logic [2:0]  flags_q, flags_d;

  logic        hazard;
  logic        accept;
  logic        acc_alu;
  logic        acc_li;

  assign op   = in_instr[15:12];
  assign rd   = in_instr[11:9];
  assign rs1  = in_instr[8:6];
  assign rs2  = in_instr[5:3];
  assign imm8 = in_instr[7:0];

  always_comb begin
    cls = CLS_ALU;
    case (op)
      4'b0000:                            cls = CLS_NOP;
      4'b0001:                            cls = CLS_LI;
      4'b0010, 4'b0011, 4'b1110, 4'b1111: cls = CLS_ILL;
      default:                            cls = CLS_ALU;
    endcase
  end

  function automatic logic pending(input slot_t a, input slot_t b, input logic [2:0] r);
    return (a.vld && (a.rd == r)) || (b.vld && (b.rd == r));
  endfunction

  // No bypass from the writeback edge: a reader waits until the producer has left S2.
  always_comb begin
    hazard = 1'b0;
    if (in_valid) begin
      case (cls)
        CLS_ALU: hazard = pending(s1_q, s2_q, rs1) || pending(s1_q, s2_q, rs2) ||
                          pending(s1_q, s2_q, rd);
        CLS_LI:  hazard = pending(s1_q, s2_q, rd);
        default: hazard = 1'b0;
      endcase
    end
  end

  assign in_ready = ~rst & ~hazard;
  assign accept   = in_valid & in_ready;
  assign acc_alu  = accept & (cls == CLS_ALU);
  assign acc_li   = accept & (cls == CLS_LI);

  always_comb begin
    s1_d    = '0;
    s2_d    = s1_q;
    opc_d   = '0;
    a_d     = '0;
    b_d     = '0;
    ill_d   = accept & (cls == CLS_ILL);
    flags_d = flags_q;
    if (acc_alu) begin
      s1_d  = {1'b1, rd};
      opc_d = op;
      a_d   = rf_q[rs1];
      b_d   = rf_q[rs2];
    end
    if (s2_q.vld) begin
      flags_d = {alu_carry, alu_sign, alu_overflow};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) begin
        rf_q[i] <= '0;
      end
      s1_q    <= '0;
      s2_q    <= '0;
      opc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ill_q   <= 1'b0;
      flags_q <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      opc_q   <= opc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ill_q   <= ill_d;
      flags_q <= flags_d;
      // Hazard check guarantees these two writes never target the same register.
      if (s2_q.vld) begin
        rf_q[s2_q.rd] <= alu_result;
      end
      if (acc_li) begin
        rf_q[rd] <= {{8{imm8[7]}}, imm8};
      end
    end
  end

  assign alu_opcode    = opc_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign illegal       = ill_q;
  assign flag_carry    = flags_q[2];
  assign flag_sign     = flags_q[1];
  assign flag_overflow = flags_q[0];
  assign busy          = s1_q.vld | s2_q.vld;
  assign dbg_data      = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: a per-cycle vector table plus hand-written
// sequences for reset mid-flight, first post-reset acceptance and stall corners.
module tb_alu_issue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;
  logic        alu_carry;
  logic        alu_sign;
  logic        alu_overflow;
  logic        flag_carry;
  logic        flag_sign;
  logic        flag_overflow;
  logic        illegal;
  logic        busy;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_checks;
  int n_fail;

  alu_issue dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_ready     (in_ready),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_sign     (alu_sign),
    .alu_overflow (alu_overflow),
    .flag_carry   (flag_carry),
    .flag_sign    (flag_sign),
    .flag_overflow(flag_overflow),
    .illegal      (illegal),
    .busy         (busy),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row per clock: inputs held across the edge, in_ready expected before it,
  // everything else expected just after it.
  typedef struct packed {
    logic        v;
    logic [15:0] instr;
    logic [15:0] res;
    logic [2:0]  fl_in;
    logic [2:0]  dbg;
    logic        rdy;
    logic [3:0]  opc;
    logic [15:0] a;
    logic [15:0] b;
    logic        ill;
    logic        bsy;
    logic [15:0] dval;
    logic [2:0]  fl;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic v, input logic [15:0] instr, input logic [15:0] res,
                              input logic [2:0] fl_in, input logic [2:0] dbg, input logic rdy,
                              input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b,
                              input logic ill, input logic bsy, input logic [15:0] dval,
                              input logic [2:0] fl);
    vec_t r;
    r.v = v; r.instr = instr; r.res = res; r.fl_in = fl_in; r.dbg = dbg;
    r.rdy = rdy; r.opc = opc; r.a = a; r.b = b; r.ill = ill; r.bsy = bsy;
    r.dval = dval; r.fl = fl;
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] flags();
    return {flag_carry, flag_sign, flag_overflow};
  endfunction

  task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] res,
                       input logic [2:0] fl_in, input logic [2:0] dbg);
    @(negedge clk);
    in_valid = v;
    in_instr = instr;
    alu_result = res;
    {alu_carry, alu_sign, alu_overflow} = fl_in;
    dbg_addr = dbg;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    alu_result = '0;
    {alu_carry, alu_sign, alu_overflow} = 3'b000;
    dbg_addr = '0;

    //          v  instr    res      flin    dbg  rdy opc  a        b        ill bsy dval     fl
    tbl[0]  = mk(1, 16'h1205, 16'h0000, 3'b000, 3'd1, 1, 4'h0, 16'h0000, 16'h0000, 0, 0, 16'h0005, 3'b000);
    tbl[1]  = mk(1, 16'h147F, 16'h0000, 3'b000, 3'd2, 1, 4'h0, 16'h0000, 16'h0000, 0, 0, 16'h007F, 3'b000);
    tbl[2]  = mk(1, 16'h16F0, 16'h0000, 3'b000, 3'd3, 1, 4'h0, 16'h0000, 16'h0000, 0, 0, 16'hFFF0, 3'b000);
    tbl[3]  = mk(1, 16'h4650, 16'h0000, 3'b000, 3'd3, 1, 4'h4, 16'h0005, 16'h007F, 0, 1, 16'hFFF0, 3'b000);
    tbl[4]  = mk(1, 16'h8AC0, 16'h0000, 3'b000, 3'd3, 0, 4'h0, 16'h0000, 16'h0000, 0, 1, 16'hFFF0, 3'b000);
    tbl[5]  = mk(1, 16'h8AC0, 16'h0084, 3'b000, 3'd3, 0, 4'h0, 16'h0000, 16'h0000, 0, 0, 16'h0084, 3'b000);
    tbl[6]  = mk(1, 16'h8AC0, 16'h0000, 3'b000, 3'd5, 1, 4'h8, 16'h0084, 16'h0000, 0, 1, 16'h0000, 3'b000);
    tbl[7]  = mk(0, 16'h0000, 16'h0000, 3'b000, 3'd5, 1, 4'h0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 3'b000);
    tbl[8]  = mk(0, 16'h0000, 16'h1234, 3'b101, 3'd5, 1, 4'h0, 16'h0000, 16'h0000, 0, 0, 16'h1234, 3'b101);
    tbl[9]  = mk(1, 16'hE000, 16'h0000, 3'b000, 3'd5, 1, 4'h0, 16'h0000, 16'h0000, 1, 0, 16'h1234, 3'b101);
    tbl[10] = mk(0, 16'h0000, 16'h0000, 3'b000, 3'd5, 1, 4'h0, 16'h0000, 16'h0000, 0, 0, 16'h1234, 3'b101);
    tbl[11] = mk(1, 16'h4850, 16'h0000, 3'b000, 3'd4, 1, 4'h4, 16'h0005, 16'h007F, 0, 1, 16'h0000, 3'b101);
    tbl[12] = mk(1, 16'h5CE8, 16'h0000, 3'b000, 3'd4, 1, 4'h5, 16'h0084, 16'h1234, 0, 1, 16'h0000, 3'b101);
    tbl[13] = mk(1, 16'h6E58, 16'hAAAA, 3'b001, 3'd4, 1, 4'h6, 16'h0005, 16'h0084, 0, 1, 16'hAAAA, 3'b001);
    tbl[14] = mk(1, 16'hD0A8, 16'hBBBB, 3'b010, 3'd6, 1, 4'hD, 16'h007F, 16'h1234, 0, 1, 16'hBBBB, 3'b010);
    tbl[15] = mk(0, 16'h0000, 16'hCCCC, 3'b100, 3'd7, 1, 4'h0, 16'h0000, 16'h0000, 0, 1, 16'hCCCC, 3'b100);
    tbl[16] = mk(0, 16'h0000, 16'hDDDD, 3'b011, 3'd0, 1, 4'h0, 16'h0000, 16'h0000, 0, 0, 16'hDDDD, 3'b011);
    tbl[17] = mk(0, 16'h0000, 16'hFFFF, 3'b111, 3'd0, 1, 4'h0, 16'h0000, 16'h0000, 0, 0, 16'hDDDD, 3'b011);
    tbl[18] = mk(1, 16'h1A80, 16'h0000, 3'b000, 3'd5, 1, 4'h0, 16'h0000, 16'h0000, 0, 0, 16'hFF80, 3'b011);
    tbl[19] = mk(1, 16'h0FFF, 16'h0000, 3'b000, 3'd5, 1, 4'h0, 16'h0000, 16'h0000, 0, 0, 16'hFF80, 3'b011);

    // Reset held with an instruction offered: nothing is accepted.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h1205, 16'h0000, 3'b000, 3'd1);
      check("rst in_ready", {15'd0, in_ready}, 16'd0);
      after_edge();
    end
    check("rst opcode", {12'd0, alu_opcode}, 16'd0);
    check("rst alu_a", alu_a, 16'd0);
    check("rst alu_b", alu_b, 16'd0);
    check("rst illegal", {15'd0, illegal}, 16'd0);
    check("rst busy", {15'd0, busy}, 16'd0);
    check("rst flags", {13'd0, flags()}, 16'd0);
    check("rst r1", dbg_data, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].instr, tbl[i].res, tbl[i].fl_in, tbl[i].dbg);
      check($sformatf("row%0d in_ready", i), {15'd0, in_ready}, {15'd0, tbl[i].rdy});
      after_edge();
      check($sformatf("row%0d opcode", i), {12'd0, alu_opcode}, {12'd0, tbl[i].opc});
      check($sformatf("row%0d alu_a", i), alu_a, tbl[i].a);
      check($sformatf("row%0d alu_b", i), alu_b, tbl[i].b);
      check($sformatf("row%0d illegal", i), {15'd0, illegal}, {15'd0, tbl[i].ill});
      check($sformatf("row%0d busy", i), {15'd0, busy}, {15'd0, tbl[i].bsy});
      check($sformatf("row%0d dbg", i), dbg_data, tbl[i].dval);
      check($sformatf("row%0d flags", i), {13'd0, flags()}, {13'd0, tbl[i].fl});
    end

    // Reset the cycle after accepting an ALU op; the pending writeback must be dropped.
    drive(1'b1, 16'h4650, 16'h0000, 3'b000, 3'd3);
    after_edge();
    check("mid opcode", {12'd0, alu_opcode}, 16'h0004);
    check("mid busy", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    drive(1'b1, 16'h14CD, 16'h0000, 3'b000, 3'd3);
    check("mid rst in_ready", {15'd0, in_ready}, 16'd0);
    after_edge();
    rst = 1'b0;
    // First edge after reset: accepts LI r1 while the stale result is presented.
    drive(1'b1, 16'h1205, 16'h5555, 3'b111, 3'd3);
    check("post rst in_ready", {15'd0, in_ready}, 16'd1);
    after_edge();
    check("post r3", dbg_data, 16'd0);
    check("post busy", {15'd0, busy}, 16'd0);
    check("post flags", {13'd0, flags()}, 16'd0);
    check("post illegal", {15'd0, illegal}, 16'd0);
    check("post opcode", {12'd0, alu_opcode}, 16'd0);
    dbg_addr = 3'd2;
    #1 check("post r2 ignored", dbg_data, 16'd0);
    dbg_addr = 3'd1;
    #1 check("post r1 li", dbg_data, 16'h0005);

    // LI to an in-flight rd stalls; an illegal op naming that rd does not.
    drive(1'b1, 16'h4650, 16'h0000, 3'b000, 3'd3);
    check("haz alu in_ready", {15'd0, in_ready}, 16'd1);
    after_edge();
    check("haz alu_a", alu_a, 16'h0005);
    check("haz alu_b", alu_b, 16'h0000);
    drive(1'b1, 16'h16F0, 16'h0000, 3'b000, 3'd3);
    check("haz li in_ready", {15'd0, in_ready}, 16'd0);
    after_edge();
    check("haz li r3", dbg_data, 16'd0);
    drive(1'b1, 16'h3600, 16'h0042, 3'b010, 3'd3);
    check("haz ill in_ready", {15'd0, in_ready}, 16'd1);
    after_edge();
    check("haz ill pulse", {15'd0, illegal}, 16'd1);
    check("haz wb r3", dbg_data, 16'h0042);
    check("haz wb flags", {13'd0, flags()}, 16'h0002);
    check("haz busy", {15'd0, busy}, 16'd0);
    drive(1'b0, 16'h0000, 16'h0000, 3'b000, 3'd3);
    after_edge();
    check("haz ill clear", {15'd0, illegal}, 16'd0);
    check("haz r3 hold", dbg_data, 16'h0042);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
